// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bus: read ports, issue reservation, writeback and flush.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(NUM_REGS + 1);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   issue_ready;
  logic                   wb_valid;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   flush;
  logic [CW-1:0]          busy_count;

  modport master (
    output rd_addr, issue_valid, issue_rd, wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, issue_ready, busy_count
  );

  modport slave (
    input  rd_addr, issue_valid, issue_rd, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, issue_ready, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, writeback bypass and a per-register
// busy scoreboard used by decode for RAW/WAW hazard detection.
module regfile_scoreboard #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  regfile_scoreboard_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(NUM_REGS + 1);

  logic [XLEN-1:0]     rf [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [CW-1:0]       count_next;
  logic                wb_hit;
  logic                issue_fire;

  // x0 is never written, so rf[0] stays at its reset value of zero
  assign wb_hit = !reset && bus.wb_valid && (bus.wb_addr != '0);

  assign bus.issue_ready = !reset &&
                           !(busy[bus.issue_rd] && !(bus.wb_valid && (bus.wb_addr == bus.issue_rd)));

  assign issue_fire = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

  // Read ports with optional same-cycle writeback forwarding
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp;
    assign ra  = bus.rd_addr[k*AW +: AW];
    assign byp = (WB_BYPASS != 0) && wb_hit && (bus.wb_addr == ra);
    assign bus.rd_data[k*XLEN +: XLEN] = byp ? bus.wb_data : rf[ra];
    assign bus.rd_busy[k]              = byp ? 1'b0 : busy[ra];
  end

  // Next scoreboard: retire, then reserve (set wins), then flush (clears all)
  always_comb begin
    busy_next = busy;
    if (wb_hit)     busy_next[bus.wb_addr]  = 1'b0;
    if (issue_fire) busy_next[bus.issue_rd] = 1'b1;
    if (bus.flush)  busy_next               = '0;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    count_next = '0;
    for (int i = 1; i < NUM_REGS; i++) count_next = count_next + CW'(busy_next[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= '0;
      bus.busy_count <= '0;
    end else begin
      busy           <= busy_next;
      bus.busy_count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // A stalled issue request must keep its destination until accepted or flushed
  property p_issue_hold;
    @(posedge clk) disable iff (reset)
      (bus.issue_valid && !bus.issue_ready && !bus.flush) |=>
        (bus.issue_valid && (bus.issue_rd == $past(bus.issue_rd)));
  endproperty
  a_issue_hold: assert property (p_issue_hold);

endmodule
